// File: rtl/disp_median3x3_filter.sv
// 3x3 median filter for the post-processed disparity stream.
// Two line buffers hold the previous rows. A 3-column window feeds a 3-stage
// sort pipeline. After the last input pixel of a frame, the filter flushes the
// remaining W+1 border pixels by itself.
`timescale 1ns/1ps

module disp_median3x3_filter #(
  parameter int DWIDTH    = 9,
  parameter int AWIDTH    = 11,
  parameter int MAX_WIDTH = 512
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clken,
  input  logic [AWIDTH-1:0] width,
  input  logic [AWIDTH-1:0] height,
  input  logic              enable,
  input  logic              sof,
  input  logic              valid_in,
  input  logic [DWIDTH-1:0] disp_in,
  output logic              valid_out,
  output logic [DWIDTH-1:0] disp_out,
  output logic              eof_out,
  output logic              frame_err
);
  localparam int LAW = $clog2(MAX_WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;
  typedef logic [DWIDTH-1:0] pix_t;

  function automatic pix_t min2(input pix_t a, input pix_t b);
    return (a < b) ? a : b;
  endfunction
  function automatic pix_t max2(input pix_t a, input pix_t b);
    return (a > b) ? a : b;
  endfunction
  function automatic pix_t med3(input pix_t a, input pix_t b, input pix_t c);
    return max2(min2(a, b), min2(max2(a, b), c));
  endfunction

  state_t            state_q;
  logic [AWIDTH-1:0] col_q, row_q, col_d, row_d, fcnt_q, ocol_q, orow_q, pr, pc;
  logic              byp_q;
  logic              accept, start, take, flush_step, issue, last_in, last_flush;
  logic              col_wrap, err, border;

  pix_t lb0 [MAX_WIDTH];
  pix_t lb1 [MAX_WIDTH];
  pix_t rd0_q, rd1_q;

  logic [2:0][DWIDTH-1:0]      ca_q, cb_q, nc;
  logic [2:0][2:0][DWIDTH-1:0] win, srt, s1_q;
  logic v1_q, brd1_q, eof1_q, v2_q, brd2_q, eof2_q, vout_q, eof_q, err_q;
  pix_t cen1_q, cen2_q, a2_q, b2_q, c2_q, dout_q;

  // Accept/issue decode and next input position
  always_comb begin
    accept     = clken & valid_in;
    start      = accept & sof & (state_q != FLUSH);
    take       = start | (accept & (state_q == RUN));
    flush_step = clken & (state_q == FLUSH);
    err        = accept & ((state_q == FLUSH) | ((state_q == IDLE) & ~sof) |
                           ((state_q == RUN) & sof));
    pr         = start ? '0 : row_q;
    pc         = start ? '0 : col_q;
    col_wrap   = (pc == width - 1'b1);
    last_in    = take & col_wrap & (pr == height - 1'b1);
    last_flush = flush_step & (fcnt_q == width);
    issue      = flush_step |
                 (take & ~start & ((pr >= AWIDTH'(2)) | ((pr == AWIDTH'(1)) & (pc != '0))));
    col_d = col_q;
    row_d = row_q;
    if (take | flush_step) begin
      col_d = col_wrap ? '0 : pc + 1'b1;
      row_d = col_wrap ? pr + 1'b1 : pr;
    end
    nc     = {disp_in, rd1_q, rd0_q};
    border = byp_q | (ocol_q == '0) | (orow_q == '0) |
             (ocol_q == width - 1'b1) | (orow_q == height - 1'b1);
  end

  // Frame FSM, input position, flush count and output position
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      col_q   <= '0;
      row_q   <= '0;
      fcnt_q  <= '0;
      ocol_q  <= '0;
      orow_q  <= '0;
      byp_q   <= 1'b0;
    end else if (clken) begin
      col_q <= col_d;
      row_q <= row_d;
      if (last_in) begin
        state_q <= FLUSH;
        fcnt_q  <= '0;
      end else if (start) begin
        state_q <= RUN;
      end else if (last_flush) begin
        state_q <= IDLE;
      end
      if (flush_step) fcnt_q <= fcnt_q + 1'b1;
      if (start) begin
        byp_q  <= ~enable | (width < AWIDTH'(3)) | (height < AWIDTH'(3));
        ocol_q <= '0;
        orow_q <= '0;
      end else if (issue) begin
        if (ocol_q == width - 1'b1) begin
          ocol_q <= '0;
          orow_q <= orow_q + 1'b1;
        end else begin
          ocol_q <= ocol_q + 1'b1;
        end
      end
    end
  end

  // Line buffers. The read is prefetched at the next column so the registered
  // data is already waiting when that column's pixel is accepted. The write in
  // the same cycle goes to a different column, so this matches read-before-write.
  always_ff @(posedge clk) begin
    if (clken) begin
      if (take) begin
        lb0[pc[LAW-1:0]] <= rd1_q;
        lb1[pc[LAW-1:0]] <= disp_in;
      end
      rd0_q <= lb0[col_d[LAW-1:0]];
      rd1_q <= lb1[col_d[LAW-1:0]];
    end
  end

  // Column sort of the three window columns
  always_comb begin
    win[0] = ca_q;
    win[1] = cb_q;
    win[2] = nc;
    for (int unsigned i = 0; i < 3; i++) begin
      srt[i][0] = min2(min2(win[i][0], win[i][1]), win[i][2]);
      srt[i][1] = med3(win[i][0], win[i][1], win[i][2]);
      srt[i][2] = max2(max2(win[i][0], win[i][1]), win[i][2]);
    end
  end

  // Window shift and three-stage median pipeline
  always_ff @(posedge clk) begin
    if (rst) begin
      ca_q   <= '0;
      cb_q   <= '0;
      s1_q   <= '0;
      v1_q   <= 1'b0;
      brd1_q <= 1'b0;
      eof1_q <= 1'b0;
      cen1_q <= '0;
      a2_q   <= '0;
      b2_q   <= '0;
      c2_q   <= '0;
      v2_q   <= 1'b0;
      brd2_q <= 1'b0;
      eof2_q <= 1'b0;
      cen2_q <= '0;
      vout_q <= 1'b0;
      eof_q  <= 1'b0;
      dout_q <= '0;
    end else if (clken) begin
      if (take | flush_step) begin
        ca_q <= cb_q;
        cb_q <= nc;
      end
      s1_q   <= srt;
      v1_q   <= issue;
      brd1_q <= border;
      eof1_q <= last_flush;
      cen1_q <= cb_q[1];
      a2_q   <= max2(max2(s1_q[0][0], s1_q[1][0]), s1_q[2][0]);
      b2_q   <= med3(s1_q[0][1], s1_q[1][1], s1_q[2][1]);
      c2_q   <= min2(min2(s1_q[0][2], s1_q[1][2]), s1_q[2][2]);
      v2_q   <= v1_q;
      brd2_q <= brd1_q;
      eof2_q <= eof1_q;
      cen2_q <= cen1_q;
      vout_q <= v2_q;
      eof_q  <= eof2_q & v2_q;
      dout_q <= brd2_q ? cen2_q : med3(a2_q, b2_q, c2_q);
    end
  end

  // Error pulse for dropped input or aborted frame
  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err;
  end

  assign valid_out = vout_q;
  assign disp_out  = dout_q;
  assign eof_out   = eof_q;
  assign frame_err = err_q;
endmodule

// File: tb/tb_disp_median3x3_filter.sv
// Directed bench for disp_median3x3_filter. Frame vectors come from a table.
// A reference median model (a full 9-value sort) supplies the expected outputs.
// Hand-written sequences cover the reset, stray-pixel, abort and reset-in-flush cases.
`timescale 1ns/1ps

module tb_disp_median3x3_filter;
  localparam int DW = 9;
  localparam int AW = 11;

  logic          clk = 1'b0;
  logic          rst, clken, enable, sof, valid_in;
  logic [AW-1:0] width, height;
  logic [DW-1:0] disp_in;
  logic          valid_out, eof_out, frame_err;
  logic [DW-1:0] disp_out;

  disp_median3x3_filter #(.DWIDTH(DW), .AWIDTH(AW), .MAX_WIDTH(512)) dut (
    .clk(clk), .rst(rst), .clken(clken), .width(width), .height(height),
    .enable(enable), .sof(sof), .valid_in(valid_in), .disp_in(disp_in),
    .valid_out(valid_out), .disp_out(disp_out), .eof_out(eof_out),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  typedef struct { logic [DW-1:0] d; logic eof; } exp_t;
  typedef struct { int w; int h; bit en; int pat; bit gaps; bit stray; } vec_t;

  exp_t          expq[$];
  logic [DW-1:0] pix [0:255];
  int            nvec = 0, nmis = 0;
  int            cyc = 0;
  logic          ce_last = 1'b0;
  int            n_eof = 0, n_err = 0, first_out_cyc = -1, acc_cyc = 0;

  always @(posedge clk) begin
    cyc     <= cyc + 1;
    ce_last <= clken;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  // Output monitor: one comparison per new output word
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (frame_err) n_err++;
        if (ce_last && valid_out) begin
          if (first_out_cyc < 0) first_out_cyc = cyc;
          if (eof_out) n_eof++;
          nvec++;
          if (expq.size() == 0) begin
            nmis++;
            $display("FAIL extra_out: got disp=%0d eof=%0d, required no output", disp_out, eof_out);
          end else begin
            e = expq.pop_front();
            if (disp_out !== e.d || eof_out !== e.eof) begin
              nmis++;
              $display("FAIL out: got disp=%0d eof=%0d, required disp=%0d eof=%0d",
                       disp_out, eof_out, e.d, e.eof);
            end
          end
        end
      end
    end
  end

  task automatic chk(input string name, input int got, input int req);
    nvec++;
    if (got != req) begin
      nmis++;
      $display("FAIL %s: got %0d, required %0d", name, got, req);
    end
  endtask

  task automatic drive(input logic ce, input logic v, input logic s, input logic [DW-1:0] d);
    clken = ce; valid_in = v; sof = s; disp_in = d;
    @(posedge clk);
    #1;
  endtask

  task automatic gen(input int w, input int h, input int pat);
    for (int k = 0; k < w * h; k++) begin
      case (pat)
        0:       pix[k] = DW'(7);
        1:       pix[k] = (k == 2 * w + 2) ? DW'(200) : DW'(0);
        2:       pix[k] = DW'(k);
        default: pix[k] = DW'($urandom_range(0, 511));
      endcase
    end
  endtask

  // Reference: border/bypass passes the centre pixel; interior is the true 9-value median
  task automatic model(input int w, input int h, input bit en, input int nout);
    int   v[9];
    int   t, r, c;
    exp_t e;
    for (int j = 0; j < nout; j++) begin
      r = j / w;
      c = j % w;
      if (!en || r == 0 || c == 0 || r == h - 1 || c == w - 1) begin
        e.d = pix[j];
      end else begin
        for (int dr = 0; dr < 3; dr++)
          for (int dc = 0; dc < 3; dc++)
            v[dr * 3 + dc] = int'(pix[(r + dr - 1) * w + c + dc - 1]);
        for (int a = 0; a < 9; a++)
          for (int b = 0; b < 8 - a; b++)
            if (v[b] > v[b + 1]) begin t = v[b]; v[b] = v[b + 1]; v[b + 1] = t; end
        e.d = DW'(v[4]);
      end
      e.eof = (j == w * h - 1);
      expq.push_back(e);
    end
  endtask

  task automatic send(input int w, input int first, input int last, input bit gaps);
    logic ce;
    for (int k = first; k <= last; k++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          ce = 1'($urandom_range(0, 1));
          drive(ce, ce ? 1'b0 : 1'($urandom_range(0, 1)), 1'b0, DW'($urandom_range(0, 511)));
        end
      end
      if (k == w + 1) acc_cyc = cyc;
      drive(1'b1, 1'b1, (k == 0), pix[k]);
    end
  endtask

  task automatic drain(input bit gaps);
    int t = 0;
    while (expq.size() > 0 && t < 3000) begin
      drive(gaps ? 1'($urandom_range(0, 1)) : 1'b1, 1'b0, 1'b0, '0);
      t++;
    end
    chk("drain_left", expq.size(), 0);
    expq.delete();
    repeat (6) drive(1'b1, 1'b0, 1'b0, '0);
  endtask

  task automatic run_frame(input vec_t v, input string name);
    width = AW'(v.w); height = AW'(v.h); enable = v.en;
    gen(v.w, v.h, v.pat);
    model(v.w, v.h, v.en, v.w * v.h);
    n_eof = 0; n_err = 0; first_out_cyc = -1;
    send(v.w, 0, v.w * v.h - 1, v.gaps);
    if (v.stray) drive(1'b1, 1'b1, 1'b0, DW'(5));
    drain(v.gaps);
    chk({name, "_eof_count"}, n_eof, 1);
    chk({name, "_err_count"}, n_err, int'(v.stray));
    if (!v.gaps) chk({name, "_latency"}, first_out_cyc - acc_cyc, 3);
  endtask

  vec_t tbl[6];

  initial begin
    tbl[0] = '{w: 5,  h: 4, en: 1'b1, pat: 0, gaps: 1'b0, stray: 1'b0};
    tbl[1] = '{w: 5,  h: 5, en: 1'b1, pat: 1, gaps: 1'b0, stray: 1'b0};
    tbl[2] = '{w: 4,  h: 3, en: 1'b0, pat: 2, gaps: 1'b0, stray: 1'b0};
    tbl[3] = '{w: 16, h: 8, en: 1'b1, pat: 3, gaps: 1'b1, stray: 1'b0};
    tbl[4] = '{w: 3,  h: 3, en: 1'b1, pat: 3, gaps: 1'b0, stray: 1'b1};
    tbl[5] = '{w: 8,  h: 4, en: 1'b1, pat: 3, gaps: 1'b1, stray: 1'b0};

    rst = 1'b1; clken = 1'b0; valid_in = 1'b0; sof = 1'b0; disp_in = '0;
    width = AW'(5); height = AW'(4); enable = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid_out", valid_out, 0);
    chk("rst_disp_out", disp_out, 0);
    chk("rst_eof_out", eof_out, 0);
    chk("rst_frame_err", frame_err, 0);
    rst = 1'b0;
    drive(1'b1, 1'b0, 1'b0, '0);

    for (int i = 0; i < 6; i++) run_frame(tbl[i], $sformatf("vec%0d", i));

    // Stray pixel in IDLE: dropped with an error pulse, no output
    n_err = 0;
    drive(1'b1, 1'b1, 1'b0, DW'(33));
    repeat (5) drive(1'b1, 1'b0, 1'b0, '0);
    chk("idle_stray_err", n_err, 1);

    // sof at k=9 aborts the frame; the first three outputs are already issued
    width = AW'(5); height = AW'(4); enable = 1'b1;
    gen(5, 4, 3);
    model(5, 4, 1'b1, 3);
    n_eof = 0; n_err = 0;
    send(5, 0, 8, 1'b0);
    gen(5, 4, 3);
    model(5, 4, 1'b1, 20);
    send(5, 0, 19, 1'b0);
    drain(1'b0);
    chk("abort_err_count", n_err, 1);
    chk("abort_eof_count", n_eof, 1);

    // Reset during FLUSH clears outputs; the next frame must be normal
    gen(5, 4, 3);
    model(5, 4, 1'b1, 20);
    send(5, 0, 19, 1'b0);
    repeat (2) drive(1'b1, 1'b0, 1'b0, '0);
    rst = 1'b1;
    drive(1'b1, 1'b0, 1'b0, '0);
    chk("flush_rst_valid_out", valid_out, 0);
    chk("flush_rst_disp_out", disp_out, 0);
    chk("flush_rst_eof_out", eof_out, 0);
    chk("flush_rst_frame_err", frame_err, 0);
    expq.delete();
    rst = 1'b0;
    drive(1'b1, 1'b0, 1'b0, '0);
    run_frame(tbl[5], "post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
